// File: rtl/grid_reader_if.sv
// Row stream bus between grid_reader and the LED-matrix/VGA row driver.
//   rowValid : row presented (master -> slave)
//   rowIndex : index of presented row (master -> slave)
//   rowData  : row contents, bit c = column c (master -> slave)
//   rowReady : consumer accepts the presented row (slave -> master)
interface grid_reader_if #(
   parameter int COLS = 16
);
   logic            rowValid;
   logic [3:0]      rowIndex;
   logic [COLS-1:0] rowData;
   logic            rowReady;

   modport master (
      output rowValid,
      output rowIndex,
      output rowData,
      input  rowReady
   );

   modport slave (
      input  rowValid,
      input  rowIndex,
      input  rowData,
      output rowReady
   );
endinterface

// File: rtl/grid_reader.sv
// Frame reader for the cell board. A frame request snapshots the board and
// cursor state, then streams one row per handshake (row 0 first), with an
// optional blinking cursor bit XORed into the cursor's row.
//   clk       : clock, rising edge
//   reset     : synchronous, active-low
//   grid      : live board, grid[r][c] = row r, column c
//   cursorRow : cursor row
//   cursorCol : cursor column
//   cursorEn  : cursor overlay enable
//   start     : frame request, accepted only when idle
//   frameDone : one-cycle pulse after the last row transfers
//   busy      : high whenever a frame is in progress
//   row_bus   : row stream (rowValid/rowIndex/rowData out, rowReady in)
module grid_reader #(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ROWS-1:0][COLS-1:0] grid,
   input  logic [3:0]                cursorRow,
   input  logic [3:0]                cursorCol,
   input  logic                      cursorEn,
   input  logic                      start,
   output logic                      frameDone,
   output logic                      busy,
   grid_reader_if.master             row_bus
);

   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [3:0]       LAST_ROW = 4'(ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic                      accept;
   logic                      advance;

   logic [3:0]                row_cnt;
   logic [ROWS-1:0][COLS-1:0] snapshot;
   logic [3:0]                cur_row;
   logic [3:0]                cur_col;
   logic                      cur_en;
   logic                      cur_phase;

   logic [CNT_W-1:0]          blink_cnt;
   logic                      phase;

   logic [COLS-1:0]           mask;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         row_cnt   <= '0;
         snapshot  <= '0;
         cur_row   <= '0;
         cur_col   <= '0;
         cur_en    <= 1'b0;
         cur_phase <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         state_q <= state_d;

         // Blink generator runs in every state.
         if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         // Everything the frame shows is frozen here, so later edits
         // to grid or cursor cannot tear the frame in flight.
         if (accept) begin
            snapshot  <= grid;
            cur_row   <= cursorRow;
            cur_col   <= cursorCol;
            cur_en    <= cursorEn;
            cur_phase <= phase;
            row_cnt   <= '0;
         end else if (advance) begin
            row_cnt <= row_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (row_bus.rowReady) begin
               if (row_cnt == LAST_ROW) begin
                  state_d = DONE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A latched cursor row outside the board never equals row_cnt and a
   // column outside the board matches no bit, so neither produces overlay.
   always_comb begin
      mask = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         mask[c] = cur_en && cur_phase && (row_cnt == cur_row) && (cur_col == 4'(c));
      end
   end

   assign row_bus.rowValid = (state_q == SEND);
   assign row_bus.rowIndex = (state_q == SEND) ? row_cnt : '0;
   assign row_bus.rowData  = (state_q == SEND) ? (snapshot[row_cnt] ^ mask) : '0;
   assign frameDone        = (state_q == DONE);
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_grid_reader.sv
// Self-checking bench for grid_reader with a short blink period.
module tb_grid_reader;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int BD   = 4;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [ROWS-1:0][COLS-1:0] grid = '0;
   logic [3:0]                cursorRow = '0;
   logic [3:0]                cursorCol = '0;
   logic                      cursorEn = 1'b0;
   logic                      start = 1'b0;
   logic                      frameDone;
   logic                      busy;

   int total = 0;
   int bad   = 0;
   int edges = 0;   // clock edges since reset was last released

   grid_reader_if #(.COLS(COLS)) bus ();

   grid_reader #(
      .ROWS(ROWS),
      .COLS(COLS),
      .BLINK_DIV(BD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .grid(grid),
      .cursorRow(cursorRow),
      .cursorCol(cursorCol),
      .cursorEn(cursorEn),
      .start(start),
      .frameDone(frameDone),
      .busy(busy),
      .row_bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= reset ? edges + 1 : 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected row: board row, with the cursor bit flipped when the cursor
   // is enabled, blinking "on", and sitting in this row.
   function automatic logic [COLS-1:0] model_row(input logic [ROWS-1:0][COLS-1:0] snap,
                                                 input int r, input int cr, input int cc,
                                                 input bit en, input bit ph);
      logic [COLS-1:0] row;
      row = snap[r];
      if (en && ph && r == cr && cc < COLS) row[cc] = ~row[cc];
      return row;
   endfunction

   function automatic bit model_phase();
      return ((edges / BD) % 2) == 1;
   endfunction

   task automatic rand_grid();
      for (int r = 0; r < ROWS; r++) grid[r] = 16'($urandom);
   endtask

   task automatic diag_grid();
      grid = '0;
      for (int r = 0; r < ROWS; r++) grid[r][r] = 1'b1;
   endtask

   // Requests one frame and checks every presented row against the model.
   task automatic do_frame(input bit rand_ready, input int stall_row, input bit tamper,
                           input bit poke_start, input bit exact);
      logic [ROWS-1:0][COLS-1:0] snap;
      logic [COLS-1:0] expv;
      int cr, cc, k, cyc, stall;
      bit en, ph;
      snap = grid; cr = cursorRow; cc = cursorCol; en = cursorEn; ph = model_phase();
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0; cyc = 0; stall = 0;
      while (k < ROWS && cyc < 400) begin
         expv = model_row(snap, k, cr, cc, en, ph);
         total++;
         if (bus.rowValid !== 1'b1 || bus.rowIndex !== 4'(k) || bus.rowData !== expv ||
             busy !== 1'b1 || frameDone !== 1'b0) begin
            bad++;
            $display("FAIL row%0d: valid=%b idx=%0d data=%h busy=%b done=%b, required valid=1 idx=%0d data=%h busy=1 done=0",
                     k, bus.rowValid, bus.rowIndex, bus.rowData, busy, frameDone, k, expv);
         end
         if (k == stall_row && stall < 5) begin
            bus.rowReady = 1'b0;
            grid = '1;
            stall++;
         end else begin
            bus.rowReady = rand_ready ? 1'($urandom % 2) : 1'b1;
         end
         if (tamper) begin
            rand_grid();
            cursorRow = 4'($urandom);
            cursorCol = 4'($urandom);
            cursorEn  = 1'($urandom);
         end
         if (poke_start) start = 1'($urandom % 2);
         step();
         start = 1'b0;
         if (bus.rowReady) k++;
         cyc++;
      end
      if (k < ROWS) begin
         total++; bad++;
         $display("FAIL frame_timeout: rows transferred=%0d, required %0d", k, ROWS);
      end
      if (exact) begin
         total++;
         if (cyc != ROWS) begin
            bad++;
            $display("FAIL frame_cycles: cycles=%0d, required %0d", cyc, ROWS);
         end
      end
      total++;
      if (frameDone !== 1'b1 || bus.rowValid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL done_cycle: done=%b valid=%b busy=%b, required done=1 valid=0 busy=1",
                  frameDone, bus.rowValid, busy);
      end
      bus.rowReady = 1'($urandom % 2);
      start = poke_start;
      step();
      start = 1'b0;
      total++;
      if (frameDone !== 1'b0 || busy !== 1'b0 || bus.rowValid !== 1'b0) begin
         bad++;
         $display("FAIL after_done: done=%b busy=%b valid=%b, required all 0",
                  frameDone, busy, bus.rowValid);
      end
      step();
      total++;
      if (busy !== 1'b0 || bus.rowValid !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold: busy=%b valid=%b, required 0 0", busy, bus.rowValid);
      end
   endtask

   task automatic wait_phase(input bit want);
      int n;
      n = 0;
      while (model_phase() != want && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      bus.rowReady = 1'b0;
      step();
      step();
      total++;
      if (bus.rowValid !== 1'b0 || bus.rowIndex !== 4'd0 || bus.rowData !== '0 ||
          frameDone !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b idx=%0d data=%h done=%b busy=%b, required all 0",
                  bus.rowValid, bus.rowIndex, bus.rowData, frameDone, busy);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step();
      // Four cycles after release the blink phase is 1: cursor must show.
      grid = '0; cursorRow = 4'd2; cursorCol = 4'd3; cursorEn = 1'b1;
      do_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_streaming();
      diag_grid();
      cursorEn = 1'b0;
      do_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      diag_grid();
      cursorEn = 1'b0;
      do_frame(1'b0, 3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_cursor();
      grid = '0; cursorRow = 4'd5; cursorCol = 4'd9; cursorEn = 1'b1;
      wait_phase(1'b1);
      do_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
      grid = '0; cursorRow = 4'd5; cursorCol = 4'd9; cursorEn = 1'b1;
      wait_phase(1'b0);
      do_frame(1'b1, -1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignored();
      rand_grid();
      cursorEn = 1'b0;
      do_frame(1'b1, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_midframe();
      logic [COLS-1:0] row0;
      int n;
      rand_grid();
      cursorEn = 1'b0;
      bus.rowReady = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(bus.rowValid === 1'b1 && bus.rowIndex === 4'd7) && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL reach_row7: idx=%0d, required 7", bus.rowIndex);
      end
      reset = 1'b0;
      step();
      total++;
      if (bus.rowValid !== 1'b0 || busy !== 1'b0 || frameDone !== 1'b0 ||
          bus.rowIndex !== 4'd0 || bus.rowData !== '0) begin
         bad++;
         $display("FAIL reset_abort: valid=%b busy=%b done=%b idx=%0d data=%h, required all 0",
                  bus.rowValid, busy, frameDone, bus.rowIndex, bus.rowData);
      end
      // start held high across release is taken on the first edge.
      start = 1'b1;
      rand_grid();
      row0 = grid[0];
      reset = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (bus.rowValid !== 1'b1 || bus.rowIndex !== 4'd0 || bus.rowData !== row0) begin
         bad++;
         $display("FAIL start_after_reset: valid=%b idx=%0d data=%h, required 1 0 %h",
                  bus.rowValid, bus.rowIndex, bus.rowData, row0);
      end
      n = 0;
      while (frameDone !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n != ROWS) begin
         bad++;
         $display("FAIL frame_after_reset: cycles to done=%0d, required %0d", n, ROWS);
      end
      step();
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         rand_grid();
         cursorRow = 4'($urandom);
         cursorCol = 4'($urandom);
         cursorEn  = 1'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 5)); g++) step();
         do_frame(1'b1, -1, 1'b1, 1'b1, 1'b0);
      end
   endtask

   initial begin
      bus.rowReady = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_cursor();
      test_start_ignored();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
